// File: rtl/dbg_run_controller.sv
// dbg_run_controller
//   Sequences the debug core's run/halt/step/reset behaviour in the sys_clk
//   domain. Command strobes arrive as single-cycle pulses from the TAP-side
//   synchronizers. All outputs are registered; clk_en feeds an external
//   negedge clock-gate latch.
//
//   Optional feature macro: DBG_BREAKPOINT_EN
//     defined   -> bp_hit halts RUN / ends STEP early, adds output bp_halted
//     undefined -> bp_hit is ignored and bp_halted does not exist
//
// Ports
//   sys_clk     in   system clock, posedge
//   reset       in   synchronous active-high reset
//   cmd_halt    in   halt strobe
//   cmd_step    in   step strobe
//   cmd_resume  in   resume strobe
//   cmd_reset   in   logic-reset strobe
//   step_count  in   cycles to step, sampled on an accepted cmd_step
//   bp_hit      in   breakpoint match (optional feature only)
//   clk_en      out  core clock enable
//   halted      out  state is HALT
//   busy        out  state is STEP or RESET
//   step_done   out  one-cycle pulse on STEP -> HALT completion
//   dm_reset    out  debug-module / core reset
//   bp_halted   out  halt was caused by a breakpoint (optional feature only)

module dbg_run_controller #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned RST_CYCLES = 4,
  parameter bit          RST_HALT   = 1'b0
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             cmd_halt,
  input  logic             cmd_step,
  input  logic             cmd_resume,
  input  logic             cmd_reset,
  input  logic [CNT_W-1:0] step_count,
  input  logic             bp_hit,
  output logic             clk_en,
  output logic             halted,
  output logic             busy,
  output logic             step_done,
`ifdef DBG_BREAKPOINT_EN
  output logic             bp_halted,
`endif
  output logic             dm_reset
);

  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_STEP  = 2'd2,
    ST_RESET = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   step_cnt;
  logic [RST_W-1:0]   rst_cnt;
  logic               bp_in;

`ifdef DBG_BREAKPOINT_EN
  assign bp_in = bp_hit;
`else
  // Breakpoint input is inert in this build; constant folds the logic away.
  logic unused_bp;
  assign bp_in     = 1'b0;
  assign unused_bp = bp_hit;
`endif

  // Main sequencer: state, counters and all registered outputs.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state     <= ST_RUN;
      step_cnt  <= '0;
      rst_cnt   <= '0;
      clk_en    <= 1'b1;
      halted    <= 1'b0;
      busy      <= 1'b0;
      step_done <= 1'b0;
      dm_reset  <= 1'b0;
    end else begin
      step_done <= 1'b0;
      if (cmd_reset) begin
        // Highest priority from any state; in RESET this re-loads the counter.
        state    <= ST_RESET;
        rst_cnt  <= RST_LOAD;
        step_cnt <= '0;
        clk_en   <= 1'b1;
        halted   <= 1'b0;
        busy     <= 1'b1;
        dm_reset <= 1'b1;
      end else begin
        case (state)
          ST_RUN: begin
            if (cmd_halt || bp_in) begin
              state  <= ST_HALT;
              clk_en <= 1'b0;
              halted <= 1'b1;
            end
          end

          ST_HALT: begin
            if (cmd_halt) begin
              // No-op; also masks lower-priority strobes this cycle.
            end else if (cmd_resume) begin
              state  <= ST_RUN;
              clk_en <= 1'b1;
              halted <= 1'b0;
            end else if (cmd_step) begin
              state    <= ST_STEP;
              step_cnt <= (step_count == '0) ? CNT_W'(1) : step_count;
              clk_en   <= 1'b1;
              halted   <= 1'b0;
              busy     <= 1'b1;
            end
          end

          ST_STEP: begin
            if (cmd_halt) begin
              // Abort: no completion pulse.
              state    <= ST_HALT;
              step_cnt <= '0;
              clk_en   <= 1'b0;
              busy     <= 1'b0;
              halted   <= 1'b1;
            end else if (cmd_resume) begin
              state    <= ST_RUN;
              step_cnt <= '0;
              busy     <= 1'b0;
            end else if (bp_in || step_cnt <= CNT_W'(1)) begin
              // Last enabled cycle (or breakpoint): complete into HALT.
              state     <= ST_HALT;
              step_cnt  <= '0;
              clk_en    <= 1'b0;
              busy      <= 1'b0;
              halted    <= 1'b1;
              step_done <= 1'b1;
            end else begin
              step_cnt <= step_cnt - CNT_W'(1);
            end
          end

          ST_RESET: begin
            if (rst_cnt <= RST_W'(1)) begin
              rst_cnt  <= '0;
              dm_reset <= 1'b0;
              busy     <= 1'b0;
              if (RST_HALT) begin
                state  <= ST_HALT;
                clk_en <= 1'b0;
                halted <= 1'b1;
              end else begin
                state  <= ST_RUN;
                clk_en <= 1'b1;
                halted <= 1'b0;
              end
            end else begin
              rst_cnt <= rst_cnt - RST_W'(1);
            end
          end

          default: begin
            state    <= ST_RUN;
            step_cnt <= '0;
            rst_cnt  <= '0;
            clk_en   <= 1'b1;
            halted   <= 1'b0;
            busy     <= 1'b0;
            dm_reset <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DBG_BREAKPOINT_EN
  // Breakpoint-halt flag: set on a bp-caused entry to HALT, cleared on leaving HALT.
  always_ff @(posedge sys_clk) begin
    if (reset || cmd_reset) begin
      bp_halted <= 1'b0;
    end else begin
      case (state)
        ST_RUN:  if (!cmd_halt && bp_hit) bp_halted <= 1'b1;
        ST_HALT: if (!cmd_halt && (cmd_resume || cmd_step)) bp_halted <= 1'b0;
        ST_STEP: if (!cmd_halt && !cmd_resume && bp_hit) bp_halted <= 1'b1;
        default: bp_halted <= 1'b0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_dbg_run_controller.sv
// Directed bench for dbg_run_controller: each step drives one cycle of strobes,
// pushes the expected output vector, and compares it after the sampling edge.
// Vector order: {bp_halted, clk_en, halted, busy, step_done, dm_reset}.

module tb_dbg_run_controller;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       cmd_halt, cmd_step, cmd_resume, cmd_reset, bp_hit;
  logic [7:0] step_count;
  logic       clk_en, halted, busy, step_done, dm_reset;

  // Second instance with RST_HALT=1, driven separately.
  logic       h_cmd_reset;
  logic       h_zero;
  logic [7:0] h_sc;
  logic       h_clk_en, h_halted, h_busy, h_step_done, h_dm_reset;

`ifdef DBG_BREAKPOINT_EN
  logic bp_halted, h_bp_halted;
`endif

  int tests = 0;
  int fails = 0;
  logic [5:0] exp_q[$];

  localparam logic [5:0] E_RUN  = 6'b0_10000;
  localparam logic [5:0] E_HLT  = 6'b0_01000;
  localparam logic [5:0] E_STP  = 6'b0_10100;
  localparam logic [5:0] E_DONE = 6'b0_01010;
  localparam logic [5:0] E_RST  = 6'b0_10101;
  localparam logic [5:0] E_BPH  = 6'b1_01000;
  localparam logic [5:0] E_BPD  = 6'b1_01010;

  always #5 sys_clk = ~sys_clk;

  dbg_run_controller #(.CNT_W(8), .RST_CYCLES(4), .RST_HALT(1'b0)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .cmd_halt   (cmd_halt),
    .cmd_step   (cmd_step),
    .cmd_resume (cmd_resume),
    .cmd_reset  (cmd_reset),
    .step_count (step_count),
    .bp_hit     (bp_hit),
    .clk_en     (clk_en),
    .halted     (halted),
    .busy       (busy),
    .step_done  (step_done),
`ifdef DBG_BREAKPOINT_EN
    .bp_halted  (bp_halted),
`endif
    .dm_reset   (dm_reset)
  );

  dbg_run_controller #(.CNT_W(8), .RST_CYCLES(4), .RST_HALT(1'b1)) dut_h (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .cmd_halt   (h_zero),
    .cmd_step   (h_zero),
    .cmd_resume (h_zero),
    .cmd_reset  (h_cmd_reset),
    .step_count (h_sc),
    .bp_hit     (h_zero),
    .clk_en     (h_clk_en),
    .halted     (h_halted),
    .busy       (h_busy),
    .step_done  (h_step_done),
`ifdef DBG_BREAKPOINT_EN
    .bp_halted  (h_bp_halted),
`endif
    .dm_reset   (h_dm_reset)
  );

  function automatic logic [5:0] obs_main();
`ifdef DBG_BREAKPOINT_EN
    return {bp_halted, clk_en, halted, busy, step_done, dm_reset};
`else
    return {1'b0, clk_en, halted, busy, step_done, dm_reset};
`endif
  endfunction

  function automatic logic [5:0] obs_h();
`ifdef DBG_BREAKPOINT_EN
    return {h_bp_halted, h_clk_en, h_halted, h_busy, h_step_done, h_dm_reset};
`else
    return {1'b0, h_clk_en, h_halted, h_busy, h_step_done, h_dm_reset};
`endif
  endfunction

  // One cycle on the main instance: drive strobes, expect e after the edge.
  task automatic cyc(input string tag, input logic h, input logic s, input logic r,
                     input logic rs, input logic b, input logic [7:0] sc,
                     input logic [5:0] e);
    logic [5:0] want;
    logic [5:0] got;
    cmd_halt   = h;
    cmd_step   = s;
    cmd_resume = r;
    cmd_reset  = rs;
    bp_hit     = b;
    step_count = sc;
    exp_q.push_back(e);
    @(posedge sys_clk);
    #1;
    cmd_halt = 1'b0; cmd_step = 1'b0; cmd_resume = 1'b0; cmd_reset = 1'b0; bp_hit = 1'b0;
    want = exp_q.pop_front();
    got  = obs_main();
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
    tests++;
    assert ((halted && busy) === 1'b0) else begin
      fails++;
      $error("FAIL %s_inv: halted&busy observed %b expected 0", tag, halted && busy);
    end
  endtask

  task automatic idle(input string tag, input int n, input logic [5:0] e);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 0, 8'd0, e);
  endtask

  // One cycle on the RST_HALT=1 instance.
  task automatic hcyc(input string tag, input logic rs, input logic [5:0] e);
    logic [5:0] want;
    logic [5:0] got;
    h_cmd_reset = rs;
    exp_q.push_back(e);
    @(posedge sys_clk);
    #1;
    h_cmd_reset = 1'b0;
    want = exp_q.pop_front();
    got  = obs_h();
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_halt = 1'b0; cmd_step = 1'b0; cmd_resume = 1'b0; cmd_reset = 1'b0;
    bp_hit = 1'b0; step_count = 8'd0;
    h_cmd_reset = 1'b0; h_zero = 1'b0; h_sc = 8'd0;

    // Reset state, then idle in RUN.
    cyc("reset0", 0, 0, 0, 0, 0, 8'd0, E_RUN);
    cyc("reset1", 1, 1, 0, 1, 0, 8'd3, E_RUN);
    reset = 1'b0;
    idle("idle_run", 5, E_RUN);

    // Halt and resume.
    cyc("halt", 1, 0, 0, 0, 0, 8'd0, E_HLT);
    idle("halt_hold", 3, E_HLT);
    cyc("resume", 0, 0, 1, 0, 0, 8'd0, E_RUN);
    cyc("run_step_ign", 0, 1, 0, 0, 0, 8'd3, E_RUN);
    cyc("run_res_ign", 0, 0, 1, 0, 0, 8'd0, E_RUN);

    // Step 3 cycles.
    cyc("halt2", 1, 0, 0, 0, 0, 8'd0, E_HLT);
    cyc("step3_a", 0, 1, 0, 0, 0, 8'd3, E_STP);
    idle("step3_b", 2, E_STP);
    cyc("step3_done", 0, 0, 0, 0, 0, 8'd0, E_DONE);
    cyc("step3_after", 0, 0, 0, 0, 0, 8'd0, E_HLT);

    // step_count 0 behaves as 1.
    cyc("step0_a", 0, 1, 0, 0, 0, 8'd0, E_STP);
    cyc("step0_done", 0, 0, 0, 0, 0, 8'd0, E_DONE);
    cyc("step0_after", 0, 0, 0, 0, 0, 8'd0, E_HLT);

    // cmd_step during STEP does not reload.
    cyc("step2_a", 0, 1, 0, 0, 0, 8'd2, E_STP);
    cyc("step2_reld", 0, 1, 0, 0, 0, 8'd9, E_STP);
    cyc("step2_done", 0, 0, 0, 0, 0, 8'd0, E_DONE);
    cyc("step2_after", 0, 0, 0, 0, 0, 8'd0, E_HLT);

    // Long step aborted by halt after 5 enabled cycles.
    cyc("step200_a", 0, 1, 0, 0, 0, 8'd200, E_STP);
    idle("step200_b", 4, E_STP);
    cyc("step_abort", 1, 0, 0, 0, 0, 8'd0, E_HLT);
    cyc("abort_after", 0, 0, 0, 0, 0, 8'd0, E_HLT);

    // Resume during STEP goes to RUN.
    cyc("step50", 0, 1, 0, 0, 0, 8'd50, E_STP);
    cyc("step_resume", 0, 0, 1, 0, 0, 8'd0, E_RUN);
    cyc("step_res_after", 0, 0, 0, 0, 0, 8'd0, E_RUN);

    // Priority in HALT.
    cyc("halt3", 1, 0, 0, 0, 0, 8'd0, E_HLT);
    cyc("prio_h_r", 1, 0, 1, 0, 0, 8'd0, E_HLT);
    cyc("prio_r_s", 0, 1, 1, 0, 0, 8'd5, E_RUN);

    // Reset sequence from RUN: 4 cycles then RUN.
    cyc("rst_run_a", 0, 0, 0, 1, 0, 8'd0, E_RST);
    idle("rst_run_b", 3, E_RST);
    cyc("rst_run_exit", 0, 0, 0, 0, 0, 8'd0, E_RUN);

    // Reset beats halt; halt ignored in RESET; re-reset extends.
    cyc("rst_prio", 1, 0, 0, 1, 0, 8'd0, E_RST);
    cyc("rst_halt_ign", 1, 0, 0, 0, 0, 8'd0, E_RST);
    cyc("rst_reload", 0, 0, 0, 1, 0, 8'd0, E_RST);
    idle("rst_ext", 3, E_RST);
    cyc("rst_ext_exit", 0, 0, 0, 0, 0, 8'd0, E_RUN);

    // Reset during STEP.
    cyc("halt4", 1, 0, 0, 0, 0, 8'd0, E_HLT);
    cyc("step10", 0, 1, 0, 0, 0, 8'd10, E_STP);
    cyc("rst_step", 0, 0, 0, 1, 0, 8'd0, E_RST);
    idle("rst_step_b", 3, E_RST);
    cyc("rst_step_exit", 0, 0, 0, 0, 0, 8'd0, E_RUN);

    // Synchronous reset overrides commands while HALT.
    cyc("halt5", 1, 0, 0, 0, 0, 8'd0, E_HLT);
    reset = 1'b1;
    cyc("sync_reset", 0, 1, 0, 0, 0, 8'd4, E_RUN);
    reset = 1'b0;
    cyc("post_reset", 0, 0, 0, 0, 0, 8'd0, E_RUN);

    // RST_HALT=1 instance ends in HALT.
    hcyc("h_rst_a", 1, E_RST);
    for (int i = 0; i < 3; i++) hcyc("h_rst_b", 0, E_RST);
    hcyc("h_rst_exit", 0, E_HLT);
    hcyc("h_rst_hold", 0, E_HLT);

`ifdef DBG_BREAKPOINT_EN
    cyc("bp_run", 0, 0, 0, 0, 1, 8'd0, E_BPH);
    cyc("bp_resume", 0, 0, 1, 0, 0, 8'd0, E_RUN);
    cyc("bp_vs_halt", 1, 0, 0, 0, 1, 8'd0, E_HLT);
    cyc("bp_step", 0, 1, 0, 0, 0, 8'd10, E_STP);
    cyc("bp_step_hit", 0, 0, 0, 0, 1, 8'd0, E_BPD);
    cyc("bp_step_hold", 0, 0, 0, 0, 0, 8'd0, E_BPH);
    cyc("bp_resume2", 0, 0, 1, 0, 0, 8'd0, E_RUN);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
